// File: rtl/match_collector_pkg.sv
// -----------------------------------------------------------------------------
// match_collector_pkg
// Shared definitions for the match collector block: the report FSM state
// encoding and the default sizing constants used by the top level.
// -----------------------------------------------------------------------------
package match_collector_pkg;

  localparam int DEFAULT_NUM_ENGINES = 8;
  localparam int DEFAULT_OFFSET_W    = 16;

  // IDLE    : waiting for a stream to start
  // CAPTURE : consuming bytes, latching first-match offsets
  // DRAIN   : one extra cycle for late engine match outputs
  // REPORT  : emitting one record per matched engine
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

endpackage

// File: rtl/match_collector_lsb_find.sv
// -----------------------------------------------------------------------------
// lsb_find
// Combinational lowest-set-bit finder.
//   vec   : input bit vector
//   idx   : index of the lowest set bit (0 when vec is empty)
//   any   : at least one bit of vec is set
//   multi : more than one bit of vec is set
// -----------------------------------------------------------------------------
module lsb_find #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  localparam logic [WIDTH-1:0] ONE = 1;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[IDX_W-1:0];
    end
  end

  assign any   = |vec;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(vec & (vec - ONE));

endmodule

// File: rtl/match_collector.sv
// -----------------------------------------------------------------------------
// match_collector
// Collects sticky per-engine match lines over one data stream, remembers the
// byte offset at which each engine first matched, then reports one record per
// matching engine (lowest index first) over a valid/ready handshake.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   sod          : start of data, restarts collection from any state
//   en, eod      : byte strobe and end-of-data qualifier
//   match_in     : sticky engine match bits, bit i = engine i
//   rep_valid/rep_ready : record handshake
//   rep_id, rep_offset, rep_last, rep_nomatch : record fields
//   done         : one-cycle pulse when a stream's report completes
//   busy         : high whenever not IDLE
//
// Build option: define MATCH_COLLECTOR_NOMATCH_EN to emit a single no-match
// record (rep_nomatch=1, offset = final byte count) when no engine matched.
// Without it a stream with no matches just pulses done.
// -----------------------------------------------------------------------------
module match_collector
  import match_collector_pkg::*;
#(
  parameter int NUM_ENGINES = DEFAULT_NUM_ENGINES,
  parameter int OFFSET_W    = DEFAULT_OFFSET_W,
  parameter int ID_W        = $clog2(NUM_ENGINES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sod,
  input  logic                   en,
  input  logic                   eod,
  input  logic [NUM_ENGINES-1:0] match_in,
  output logic                   rep_valid,
  input  logic                   rep_ready,
  output logic [ID_W-1:0]        rep_id,
  output logic [OFFSET_W-1:0]    rep_offset,
  output logic                   rep_last,
  output logic                   rep_nomatch,
  output logic                   done,
  output logic                   busy
);

  localparam logic [OFFSET_W-1:0] CNT_ONE = 1;
  localparam logic [OFFSET_W-1:0] CNT_MAX = '1;

  state_t                 state;
  state_t                 next_state;
  logic                   next_done;
  logic                   clear_flag;
  logic [NUM_ENGINES-1:0] flags;
  logic [OFFSET_W-1:0]    offsets [NUM_ENGINES];
  logic [OFFSET_W-1:0]    count;
  logic [ID_W-1:0]        lsb_idx;
  logic                   lsb_any;
  logic                   lsb_multi;

  lsb_find #(
    .WIDTH (NUM_ENGINES),
    .IDX_W (ID_W)
  ) u_lsb_find (
    .vec   (flags),
    .idx   (lsb_idx),
    .any   (lsb_any),
    .multi (lsb_multi)
  );

  assign busy = (state != ST_IDLE);

  // Next-state and record outputs. Records come straight from the registered
  // flags, so they stay stable until accepted and the next one appears the
  // cycle after an accept. sod overrides everything, dropping pending records
  // without a done pulse.
  always_comb begin
    next_state  = state;
    next_done   = 1'b0;
    clear_flag  = 1'b0;
    rep_valid   = 1'b0;
    rep_id      = '0;
    rep_offset  = '0;
    rep_last    = 1'b0;
    rep_nomatch = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_CAPTURE: begin
        if (en && eod) next_state = ST_DRAIN;
      end
      ST_DRAIN: next_state = ST_REPORT;
      ST_REPORT: begin
        if (lsb_any) begin
          rep_valid  = 1'b1;
          rep_id     = lsb_idx;
          rep_offset = offsets[lsb_idx];
          rep_last   = ~lsb_multi;
          if (rep_ready) begin
            clear_flag = 1'b1;
            if (!lsb_multi) begin
              next_state = ST_IDLE;
              next_done  = 1'b1;
            end
          end
        end else begin
`ifdef MATCH_COLLECTOR_NOMATCH_EN
          rep_valid   = 1'b1;
          rep_nomatch = 1'b1;
          rep_offset  = count;
          rep_last    = 1'b1;
          if (rep_ready) begin
            next_state = ST_IDLE;
            next_done  = 1'b1;
          end
`else
          next_state = ST_IDLE;
          next_done  = 1'b1;
`endif
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (sod) begin
      next_state = ST_CAPTURE;
      next_done  = 1'b0;
    end
  end

  // State, byte counter, first-match flags and offsets. The offset stored for
  // an engine is the count before this cycle's byte is added.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
      count <= '0;
      flags <= '0;
      for (int i = 0; i < NUM_ENGINES; i++) offsets[i] <= '0;
    end else begin
      state <= next_state;
      done  <= next_done;
      if (sod) begin
        count <= '0;
        flags <= '0;
        for (int i = 0; i < NUM_ENGINES; i++) offsets[i] <= '0;
      end else begin
        if (state == ST_CAPTURE && en && count != CNT_MAX) count <= count + CNT_ONE;
        if (state == ST_CAPTURE || state == ST_DRAIN) begin
          for (int i = 0; i < NUM_ENGINES; i++) begin
            if (match_in[i] && !flags[i]) begin
              flags[i]   <= 1'b1;
              offsets[i] <= count;
            end
          end
        end
        if (clear_flag) flags[lsb_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_match_collector.sv
// -----------------------------------------------------------------------------
// tb_match_collector
// Directed bench for match_collector. Two instances share all inputs: the
// default-width one carries most checks, a 4-bit offset instance exercises
// counter saturation.
// -----------------------------------------------------------------------------
module tb_match_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        sod;
  logic        en;
  logic        eod;
  logic [7:0]  match_in;
  logic        rep_ready;

  logic        rep_valid;
  logic [2:0]  rep_id;
  logic [15:0] rep_offset;
  logic        rep_last;
  logic        rep_nomatch;
  logic        done;
  logic        busy;

  logic        s_rep_valid;
  logic [2:0]  s_rep_id;
  logic [3:0]  s_rep_offset;
  logic        s_rep_last;
  logic        s_rep_nomatch;
  logic        s_done;
  logic        s_busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  match_collector #(
    .NUM_ENGINES (8),
    .OFFSET_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sod         (sod),
    .en          (en),
    .eod         (eod),
    .match_in    (match_in),
    .rep_valid   (rep_valid),
    .rep_ready   (rep_ready),
    .rep_id      (rep_id),
    .rep_offset  (rep_offset),
    .rep_last    (rep_last),
    .rep_nomatch (rep_nomatch),
    .done        (done),
    .busy        (busy)
  );

  match_collector #(
    .NUM_ENGINES (8),
    .OFFSET_W    (4)
  ) dut_small (
    .clk         (clk),
    .rst         (rst),
    .sod         (sod),
    .en          (en),
    .eod         (eod),
    .match_in    (match_in),
    .rep_valid   (s_rep_valid),
    .rep_ready   (rep_ready),
    .rep_id      (s_rep_id),
    .rep_offset  (s_rep_offset),
    .rep_last    (s_rep_last),
    .rep_nomatch (s_rep_nomatch),
    .done        (s_done),
    .busy        (s_busy)
  );

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic applyStimulus(input logic s, input logic e, input logic d,
                               input logic [7:0] m, input logic r);
    sod       = s;
    en        = e;
    eod       = d;
    match_in  = m;
    rep_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  initial begin
    rst = 1'b1;
    // Reset together with sod: reset must win.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_valid", rep_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_id", rep_id, 0);
    checkOutput("rst_offset", rep_offset, 0);
    checkOutput("rst_last", rep_last, 0);
    checkOutput("rst_nomatch", rep_nomatch, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
    checkOutput("idle_ignores_inputs_busy", busy, 0);
    checkOutput("idle_ignores_inputs_done", done, 0);

    // Single match: engine 2 high after the 3rd byte, 5 bytes total.
    $display("[TB] single match stream");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("a_busy_capture", busy, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h04, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h04, 1'b0);
    checkOutput("a_drain_valid", rep_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h04, 1'b0);
    checkOutput("a_valid", rep_valid, 1);
    checkOutput("a_id", rep_id, 2);
    checkOutput("a_offset", rep_offset, 3);
    checkOutput("a_last", rep_last, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h04, 1'b1);
    checkOutput("a_done", done, 1);
    checkOutput("a_valid_after", rep_valid, 0);
    checkOutput("a_busy_after", busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("a_done_pulse", done, 0);

    // Two matches with backpressure: engine 1 at 2, engine 6 at 4.
    $display("[TB] two matches with backpressure");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h02, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h02, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h42, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h42, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h42, 1'b0);
    checkOutput("b_valid", rep_valid, 1);
    checkOutput("b_id", rep_id, 1);
    checkOutput("b_offset", rep_offset, 2);
    checkOutput("b_last", rep_last, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h42, 1'b0);
      checkOutput("b_hold_valid", rep_valid, 1);
      checkOutput("b_hold_id", rep_id, 1);
      checkOutput("b_hold_done", done, 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h42, 1'b1);
    checkOutput("b2_valid", rep_valid, 1);
    checkOutput("b2_id", rep_id, 6);
    checkOutput("b2_offset", rep_offset, 4);
    checkOutput("b2_last", rep_last, 1);
    checkOutput("b2_done", done, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h42, 1'b1);
    checkOutput("b_done", done, 1);
    checkOutput("b_valid_after", rep_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("b_done_once", done, 0);

    // sod together with eod restarts, then match first seen in DRAIN.
    $display("[TB] drain-cycle match");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    checkOutput("c_sod_wins_busy", busy, 1);
    for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b1, (k == 4), 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
    checkOutput("c_valid", rep_valid, 1);
    checkOutput("c_id", rep_id, 0);
    checkOutput("c_offset", rep_offset, 4);
    checkOutput("c_last", rep_last, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h01, 1'b1);
    checkOutput("c_done", done, 1);

    // No matches over 7 bytes.
    $display("[TB] no-match stream");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 7; k++) applyStimulus(1'b0, 1'b1, (k == 7), 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef MATCH_COLLECTOR_NOMATCH_EN
    checkOutput("d_valid", rep_valid, 1);
    checkOutput("d_nomatch", rep_nomatch, 1);
    checkOutput("d_id", rep_id, 0);
    checkOutput("d_offset", rep_offset, 7);
    checkOutput("d_last", rep_last, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("d_done", done, 1);
`else
    checkOutput("d_valid", rep_valid, 0);
    checkOutput("d_nomatch", rep_nomatch, 0);
    checkOutput("d_busy", busy, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("d_done", done, 1);
    checkOutput("d_valid_after", rep_valid, 0);
`endif
    checkOutput("d_busy_after", busy, 0);

    // sod while the first of two records is pending.
    $display("[TB] sod during report");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h08, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h28, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h28, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h28, 1'b0);
    checkOutput("e_valid", rep_valid, 1);
    checkOutput("e_id", rep_id, 3);
    checkOutput("e_last", rep_last, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h28, 1'b0);
    checkOutput("e_drop_valid", rep_valid, 0);
    checkOutput("e_drop_done", done, 0);
    checkOutput("e_drop_busy", busy, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h80, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h80, 1'b0);
    checkOutput("e_new_done", done, 0);
    checkOutput("e_new_id", rep_id, 7);
    checkOutput("e_new_offset", rep_offset, 1);
    checkOutput("e_new_last", rep_last, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h80, 1'b1);
    checkOutput("e_done", done, 1);

    // Saturation on the 4-bit instance: 20 bytes, match after byte 18.
    $display("[TB] offset saturation");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 20; k++) applyStimulus(1'b0, 1'b1, (k == 20), (k >= 19) ? 8'h01 : 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
    checkOutput("g_small_valid", s_rep_valid, 1);
    checkOutput("g_small_id", s_rep_id, 0);
    checkOutput("g_small_offset", s_rep_offset, 15);
    checkOutput("g_wide_offset", rep_offset, 18);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h01, 1'b1);
    checkOutput("g_small_done", s_done, 1);
    checkOutput("g_wide_done", done, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/match_collector.md
MATCH_COLLECTOR -- requirements
Module: match_collector

Interface
REQ-001 Parameter NUM_ENGINES, default 8: number of engine match lines collected.
REQ-002 Parameter OFFSET_W, default 16: width of byte-offset counter and reported offset.
REQ-003 Parameter ID_W, default $clog2(NUM_ENGINES): width of the reported engine index.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sod  input  1  start of data; same pulse that resets the engines.
REQ-007 en  input  1  byte-consume strobe shared with the engines.
REQ-008 eod  input  1  end of data; qualifies the last byte (sampled with en).
REQ-009 match_in  input  NUM_ENGINES  sticky engine out bits, bit i = engine i.
REQ-010 rep_valid  output  1  report record valid.
REQ-011 rep_ready  input  1  downstream accepts record when high with rep_valid.
REQ-012 rep_id  output  ID_W  engine index of the record.
REQ-013 rep_offset  output  OFFSET_W  byte count at first detection of that engine's match.
REQ-014 rep_last  output  1  record is final record of this stream.
REQ-015 rep_nomatch  output  1  record is the no-match record (Configuration).
REQ-016 done  output  1  one-cycle pulse when a stream's report completes.
REQ-017 busy  output  1  high in CAPTURE, DRAIN and REPORT.

Function
REQ-018 FSM states IDLE, CAPTURE, DRAIN, REPORT; sod from any state -> CAPTURE next cycle, clearing all flags, offsets and count to 0.
REQ-019 CAPTURE: each cycle en=1, byte count increments by 1, saturating at 2^OFFSET_W-1.
REQ-020 CAPTURE/DRAIN: first cycle match_in[i]=1 with flag[i]=0 sets flag[i] and stores current byte count (post-increment of prior cycles, pre-increment of this cycle) as offset[i]; later highs ignored.
REQ-021 en=1 and eod=1 in CAPTURE -> DRAIN; DRAIN lasts exactly one cycle (absorbs engine one-cycle output latency) then -> REPORT.
REQ-022 REPORT: present lowest-index set flag; rep_valid=1, rep_id, rep_offset stable until rep_ready=1; on accept clear that flag, next record presented the following cycle.
REQ-023 rep_last=1 iff presented flag is the only remaining set flag.
REQ-024 Accept with rep_last=1 -> done=1 next cycle, state IDLE.
REQ-025 REPORT entered with no flags set and no-match record disabled -> done=1 the following cycle, rep_valid never asserted, IDLE.
REQ-026 sod and eod in same cycle: sod wins. eod outside CAPTURE, en and match_in in IDLE: ignored.
REQ-027 sod during REPORT: pending records dropped, rep_valid=0 next cycle, no done pulse.
REQ-028 rep_valid shall not deassert without acceptance except on sod or rst.

Reset
REQ-029 rst=1: state IDLE, all flags, offsets, count cleared; rep_valid, rep_last, rep_nomatch, done, busy = 0; rep_id, rep_offset = 0.
REQ-030 rst has priority over sod.

Configuration
REQ-031 Macro MATCH_COLLECTOR_NOMATCH_EN defined: REPORT with no flags emits one record rep_nomatch=1, rep_id=0, rep_offset=final byte count, rep_last=1, then done per REQ-024.
REQ-032 Macro undefined: rep_nomatch tied 0; behaviour per REQ-025.

Structure
REQ-033 Shared package holds FSM state enum and default NUM_ENGINES/OFFSET_W constants.
REQ-034 One sub-module lsb_find: combinational lowest-set-bit index plus "more than one bit set" flag, instanced for REQ-022/REQ-023.

Verification
REQ-035 sod; 5 bytes en=1, match_in[2] high from cycle after 3rd byte; eod on 5th -> one record id=2 offset=3 last=1, done.
REQ-036 Engines 1 and 6 match at offsets 2 and 4, rep_ready low 3 cycles -> id=1 held stable, then id=6 last=1, done once.
REQ-037 match_in[0] first high in DRAIN after 4 bytes -> record id=0 offset=4.
REQ-038 No matches, 7 bytes -> with macro: one record nomatch=1 offset=7 last=1; without: done only, no rep_valid.
REQ-039 sod asserted while first of two records pending -> rep_valid=0 next cycle, no done, new stream captures from count 0.
REQ-040 OFFSET_W=4, 20 bytes, match after 18th -> offset=15 (saturated).
